// File: rtl/prog_countdown_timer_pkg.sv
// Shared definitions for the programmable countdown timer.
// Holds the controller state encoding and a small helper used by the top level.
package prog_countdown_timer_pkg;

   // Controller states; the encoding is fixed so that debug probes and
   // software views of the state agree across instances.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_e;

   // Smallest prescale that still yields a distinct unit boundary.
   localparam int MIN_PRESCALE = 2;

   // A fresh run (prescaler restarted) may only be launched from these states.
   function automatic logic can_launch(input state_e s);
      return (s == IDLE) || (s == DONE);
   endfunction

endpackage

// File: rtl/prog_countdown_timer_tick_prescaler.sv
// Modulo-PRESCALE up-counter that marks unit boundaries for the countdown timer.
// wrap_o is high during the last prescaler cycle of a unit while counting is enabled.
module tick_prescaler #(
   parameter int PRESCALE = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic wrap_o
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);
   localparam logic [PRE_W-1:0] ONE  = PRE_W'(1);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   assign wrap_o = en_i && (cnt_q == LAST);

   // Next phase: clear wins over counting, and the count folds back to zero after LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : (cnt_q + ONE);
      end
   end

   // Phase register; cleared by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_countdown_timer.sv
// Programmable countdown timer: a prescaler produces unit boundaries and a
// VAL_W-bit counter counts them down, with pause/resume, one-shot or
// auto-reload operation and single-cycle tick/expiry pulses. All outputs are registered.
module prog_countdown_timer #(
   parameter int PRESCALE = 25_000_000,
   parameter int VAL_W    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [VAL_W-1:0] load_val_i,
   input  logic             start_i,
   input  logic             pause_i,
   input  logic             auto_reload_i,
   output logic [VAL_W-1:0] cur_val_o,
   output logic             running_o,
   output logic             tick_o,
   output logic             expired_o
);

   import prog_countdown_timer_pkg::*;

   localparam logic [VAL_W-1:0] ONE  = VAL_W'(1);
   localparam logic [VAL_W-1:0] ZERO = '0;

   state_e           state_q;
   state_e           state_d;
   logic [VAL_W-1:0] cur_val_q;
   logic [VAL_W-1:0] cur_val_d;
   logic [VAL_W-1:0] reload_q;
   logic [VAL_W-1:0] reload_d;
   logic [VAL_W-1:0] start_val;
   logic             tick_q;
   logic             tick_d;
   logic             expired_q;
   logic             expired_d;
   logic             running_q;
   logic             pre_clr;
   logic             pre_en;
   logic             pre_wrap;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (pre_clr),
      .en_i   (pre_en),
      .wrap_o (pre_wrap)
   );

   // Command decode and next-state datapath; load beats pause, pause beats start.
   // A cycle in which pause is sampled while running still counts as a run cycle,
   // so the expiry latency excludes only the cycles actually spent in PAUSE.
   always_comb begin
      state_d   = state_q;
      cur_val_d = cur_val_q;
      reload_d  = reload_q;
      tick_d    = 1'b0;
      expired_d = 1'b0;
      pre_clr   = 1'b0;
      pre_en    = 1'b0;
      start_val = (state_q == DONE) ? reload_q : cur_val_q;

      if (load_i) begin
         cur_val_d = load_val_i;
         reload_d  = load_val_i;
         state_d   = IDLE;
         pre_clr   = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               pre_en = 1'b1;
               if (pre_wrap) begin
                  tick_d = 1'b1;
                  if (cur_val_q == ONE) begin
                     expired_d = 1'b1;
                     if (auto_reload_i && (reload_q != ZERO)) begin
                        cur_val_d = reload_q;
                     end else begin
                        cur_val_d = ZERO;
                        state_d   = DONE;
                     end
                  end else if (cur_val_q != ZERO) begin
                     cur_val_d = cur_val_q - ONE;
                  end
               end
               if (pause_i && (state_d == RUN)) begin
                  state_d = PAUSE;
               end
            end
            PAUSE: begin
               if (start_i && !pause_i) begin
                  state_d = RUN;
               end
            end
            default: begin
               if (can_launch(state_q) && start_i && !pause_i) begin
                  pre_clr   = 1'b1;
                  cur_val_d = start_val;
                  if (start_val == ZERO) begin
                     expired_d = 1'b1;
                     state_d   = DONE;
                  end else begin
                     state_d   = RUN;
                  end
               end
            end
         endcase
      end
   end

   // State, datapath and registered outputs; reset clears everything at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cur_val_q <= '0;
         reload_q  <= '0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_val_q <= cur_val_d;
         reload_q  <= reload_d;
         tick_q    <= tick_d;
         expired_q <= expired_d;
         running_q <= (state_d == RUN);
      end
   end

   assign cur_val_o = cur_val_q;
   assign running_o = running_q;
   assign tick_o    = tick_q;
   assign expired_o = expired_q;

endmodule

// File: tb/tb_prog_countdown_timer.sv
// Self-checking bench for prog_countdown_timer (PRESCALE=4, VAL_W=4).
// Stimulus runs the directed scenarios then random commands; a reference model
// pushes the expected post-edge outputs into a queue and a monitor compares them.
module tb_prog_countdown_timer;

   localparam int PRESCALE = 4;
   localparam int VAL_W    = 4;

   logic             clk         = 1'b0;
   logic             rst_n       = 1'b0;
   logic             load        = 1'b0;
   logic [VAL_W-1:0] load_val    = '0;
   logic             start       = 1'b0;
   logic             pause       = 1'b0;
   logic             auto_reload = 1'b0;
   logic [VAL_W-1:0] cur_val;
   logic             running;
   logic             tick;
   logic             expired;

   typedef struct {
      logic [VAL_W-1:0] cur;
      logic             tick;
      logic             expired;
      logic             running;
   } resp_t;

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

   resp_t expQ[$];
   int    checks = 0;
   int    errors = 0;

   mode_t mMode    = M_IDLE;
   int    mCur     = 0;
   int    mReload  = 0;
   int    mElapsed = 0;

   prog_countdown_timer #(
      .PRESCALE(PRESCALE),
      .VAL_W   (VAL_W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .load_i        (load),
      .load_val_i    (load_val),
      .start_i       (start),
      .pause_i       (pause),
      .auto_reload_i (auto_reload),
      .cur_val_o     (cur_val),
      .running_o     (running),
      .tick_o        (tick),
      .expired_o     (expired)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [VAL_W-1:0] act, input logic [VAL_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: mElapsed counts run cycles inside the current unit; a unit
   // ends after PRESCALE of them. Returns the outputs expected after this edge.
   task automatic modelStep(input logic ld, input int lv, input logic st, input logic ps,
                            input logic ar, output resp_t r);
      r.tick    = 1'b0;
      r.expired = 1'b0;
      if (ld) begin
         mCur     = lv;
         mReload  = lv;
         mMode    = M_IDLE;
         mElapsed = 0;
      end else if (mMode == M_RUN) begin
         mElapsed++;
         if (mElapsed == PRESCALE) begin
            mElapsed = 0;
            r.tick   = 1'b1;
            if (mCur == 1) begin
               r.expired = 1'b1;
               if (ar && mReload != 0) begin
                  mCur = mReload;
               end else begin
                  mCur  = 0;
                  mMode = M_DONE;
               end
            end else if (mCur > 0) begin
               mCur--;
            end
         end
         if (ps && mMode == M_RUN) mMode = M_PAUSE;
      end else if (mMode == M_PAUSE) begin
         if (st && !ps) mMode = M_RUN;
      end else if (st && !ps) begin
         if (mMode == M_DONE) mCur = mReload;
         mElapsed = 0;
         if (mCur == 0) begin
            r.expired = 1'b1;
            mMode     = M_DONE;
         end else begin
            mMode = M_RUN;
         end
      end
      r.cur     = VAL_W'(mCur);
      r.running = (mMode == M_RUN);
   endtask

   // Drive one cycle of commands on the falling edge and queue the expected response.
   task automatic applyStimulus(input logic ld, input int lv, input logic st, input logic ps, input logic ar);
      resp_t r;
      @(negedge clk);
      load        = ld;
      load_val    = VAL_W'(lv);
      start       = st;
      pause       = ps;
      auto_reload = ar;
      modelStep(ld, lv, st, ps, ar, r);
      expQ.push_back(r);
   endtask

   task automatic idleCycles(input int n, input logic ar);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, ar);
   endtask

   // Assert reset between edges, confirm the outputs drop at once, then release.
   task automatic applyReset(input int holdCycles);
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      load        = 1'b0;
      start       = 1'b0;
      pause       = 1'b0;
      auto_reload = 1'b0;
      #1;
      checkOutput("rst_cur_val", cur_val, '0);
      checkOutput("rst_tick", {3'b0, tick}, '0);
      checkOutput("rst_expired", {3'b0, expired}, '0);
      checkOutput("rst_running", {3'b0, running}, '0);
      mMode    = M_IDLE;
      mCur     = 0;
      mReload  = 0;
      mElapsed = 0;
      repeat (holdCycles) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: one registered response per clock, compared just after the edge.
   initial begin
      resp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cur_val", cur_val, e.cur);
            checkOutput("tick", {3'b0, tick}, {3'b0, e.tick});
            checkOutput("expired", {3'b0, expired}, {3'b0, e.expired});
            checkOutput("running", {3'b0, running}, {3'b0, e.running});
         end
      end
   end

   // Directed scenarios followed by randomized command traffic.
   initial begin
      logic ld, st, ps, ar;
      int   lv;
      $display("[TB] starting prog_countdown_timer bench");
      repeat (2) @(posedge clk);
      #2;
      checkOutput("init_cur_val", cur_val, '0);
      checkOutput("init_running", {3'b0, running}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // One-shot: load 3, start, run past expiry.
      applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(16, 1'b0);

      // Auto-reload with period 2 units.
      applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b1);
      idleCycles(26, 1'b1);

      // Pause held over cycles 5..14, resume at cycle 15.
      applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(4, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(10, 1'b0);

      // Zero load expires immediately without ticking.
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b0);

      // Load wins over start; load during RUN aborts the run.
      applyStimulus(1'b1, 5, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b0);
      applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
      idleCycles(6, 1'b0);

      // Reset mid-run, then start from the cleared value.
      applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(5, 1'b0);
      applyReset(2);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b0);

      // Random command mix with occasional resets.
      for (int c = 0; c < 900; c++) begin
         ld = ($urandom_range(0, 99) < 4);
         st = ($urandom_range(0, 99) < 10);
         ps = ($urandom_range(0, 99) < 7);
         ar = $urandom_range(0, 1) == 1;
         lv = $urandom_range(0, 15);
         applyStimulus(ld, lv, st, ps, ar);
         if (c % 300 == 299) applyReset($urandom_range(1, 3));
      end

      @(posedge clk);
      #2;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
